// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings, FSM states and lane helpers for the memory access unit
package mem_access_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  // Encodings that do not exist for the configured width fall back to a word access.
  function automatic logic [2:0] norm_f3(input logic [2:0] f3, input logic is64);
    return (f3 == 3'b111 || (!is64 && (f3 == F3_D || f3 == F3_WU))) ? F3_W : f3;
  endfunction

  // f3 must already be normalised; f3[1:0] then encodes log2 of the access size.
  function automatic logic misaligned(input logic [2:0] f3, input logic [2:0] off);
    return f3[1:0] == 2'b01 ? off[0] : f3[1:0] == 2'b10 ? |off[1:0] : f3[1:0] == 2'b11 ? |off : 1'b0;
  endfunction

  // Drops the offset bits below the access size so a misaligned access stays inside one word.
  function automatic logic [2:0] align_off(input logic [2:0] f3, input logic [2:0] off);
    return f3[1:0] == 2'b00 ? off : f3[1:0] == 2'b01 ? {off[2:1], 1'b0} : f3[1:0] == 2'b10 ? {off[2], 2'b00} : 3'b000;
  endfunction

  function automatic logic [7:0] byte_en(input logic [2:0] f3, input logic [2:0] off);
    logic [7:0] mask;
    mask = f3[1:0] == 2'b00 ? 8'h01 : f3[1:0] == 2'b01 ? 8'h03 : f3[1:0] == 2'b10 ? 8'h0F : 8'hFF;
    return mask << off;
  endfunction

  function automatic logic [63:0] store_lanes(input logic [2:0] f3, input logic [63:0] d);
    return f3[1:0] == 2'b00 ? {8{d[7:0]}} : f3[1:0] == 2'b01 ? {4{d[15:0]}} : f3[1:0] == 2'b10 ? {2{d[31:0]}} : d;
  endfunction

  function automatic logic [63:0] load_ext(input logic [2:0] f3, input logic [63:0] rdata, input logic [2:0] off);
    logic [63:0] s;
    s = rdata >> {off, 3'b000};
    return f3 == F3_B  ? {{56{s[7]}}, s[7:0]} :
           f3 == F3_BU ? {56'd0, s[7:0]} :
           f3 == F3_H  ? {{48{s[15]}}, s[15:0]} :
           f3 == F3_HU ? {48'd0, s[15:0]} :
           f3 == F3_W  ? {{32{s[31]}}, s[31:0]} :
           f3 == F3_WU ? {32'd0, s[31:0]} : s;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: extracts the addressed lane from a raw memory word and extends it
module load_align
  import mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);
  logic [63:0] rd64;
  logic [63:0] ext;
  logic        unused_hi;
  // Widen to the package's 64-bit helper and narrow the result back
  always_comb begin
    rd64 = '0;
    rd64[XLEN-1:0] = rdata;
    ext = load_ext(funct3, rd64, offset);
  end
  assign result    = ext[XLEN-1:0];
  assign unused_hi = ^ext;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit driving a variable-latency valid/ready data memory
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] aluResult,
  input  logic [XLEN-1:0]   aluOp2,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN/8-1:0] mem_req_be,
  output logic [XLEN-1:0]   mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic [XLEN-1:0]   readData,
  output logic              done,
  output logic              stall,
  output logic              misalign
);
  localparam int NB   = XLEN / 8;
  localparam int OW   = $clog2(NB);
  localparam bit IS64 = XLEN == 64;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_al;
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d, rdata_q, rdata_d, ld_res;
  logic              we_q, we_d, kill_q, kill_d;
  logic [2:0]        f3_q, f3_d, off_q, off_d, f3_n, off_raw, off_a;
  logic [63:0]       op2_64, lanes;
  logic [7:0]        be8;
  logic              req, mis, accept, hs, take, unused_bits;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (mem_rsp_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (ld_res)
  );

  // Decode size, lane offset, enables and replicated store data of the incoming request
  always_comb begin
    f3_n = norm_f3(funct3, IS64);
    off_raw = '0;
    off_raw[OW-1:0] = aluResult[OW-1:0];
    mis = misaligned(f3_n, off_raw);
    off_a = align_off(f3_n, off_raw);
    op2_64 = '0;
    op2_64[XLEN-1:0] = aluOp2;
    lanes = store_lanes(f3_n, op2_64);
    be8 = byte_en(f3_n, off_a);
    addr_al = aluResult;
    addr_al[OW-1:0] = '0;
  end

  assign unused_bits = ^{lanes, be8};
  assign req    = (memRead || memWrite) && !flush;
  assign accept = state_q == IDLE && req && (ALLOW_MISALIGNED || !mis);
  assign hs     = mem_req_valid && mem_req_ready;
  assign take   = mem_rsp_valid && !kill_q && !flush && (state_q == WAIT || (state_q == REQ && hs));

  // State and request/response registers
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      kill_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state: a response with the kill flag or a same-cycle flush is swallowed without done
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    kill_d  = kill_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          state_d = REQ;
          addr_d  = addr_al;
          be_d    = be8[NB-1:0];
          wdata_d = lanes[XLEN-1:0];
          we_d    = memWrite;
          f3_d    = f3_n;
          off_d   = off_a;
        end
      end
      REQ: begin
        kill_d = flush;
        if (hs) state_d = mem_rsp_valid ? (take ? RESP : IDLE) : WAIT;
        else if (flush) state_d = IDLE;
      end
      WAIT: begin
        kill_d = kill_q || flush;
        if (mem_rsp_valid) state_d = take ? RESP : IDLE;
      end
      RESP: state_d = IDLE;
    endcase
    if (take && !we_q) rdata_d = ld_res;
  end

  // Handshake and pipeline-control outputs
  always_comb begin
    mem_req_valid = state_q == REQ;
    done          = state_q == RESP;
    stall         = !resetn && (accept || state_q == REQ || state_q == WAIT);
    misalign      = !resetn && !ALLOW_MISALIGNED && state_q == IDLE && req && mis;
  end

  assign mem_req_we    = we_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_be    = be_q;
  assign mem_req_wdata = wdata_q;
  assign readData      = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench with a byte-array memory model for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        resetn, memRead, memWrite, flush, mem_req_ready, mem_rsp_valid;
  logic [2:0]  funct3;
  logic [31:0] aluResult, aluOp2, mem_rsp_rdata, mem_req_addr, mem_req_wdata, readData;
  logic [3:0]  mem_req_be;
  logic        mem_req_valid, mem_req_we, done, stall, misalign;

  typedef struct {bit mis; logic [31:0] rd;} evt_t;
  typedef struct {bit we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} req_t;
  evt_t exp_evt[$];
  req_t exp_req[$];
  logic [7:0] phys [int unsigned];
  logic [7:0] refm [int unsigned];
  int checks = 0;
  int errors = 0;
  int ready_dly = 0;
  int rsp_dly = 1;
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .resetn(resetn), .memRead(memRead), .memWrite(memWrite), .funct3(funct3),
    .aluResult(aluResult), .aluOp2(aluOp2), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_be(mem_req_be), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .readData(readData), .done(done), .stall(stall), .misalign(misalign)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input int unsigned a);
    return refm.exists(a) ? refm[a] : 8'h00;
  endfunction

  function automatic logic [7:0] phys_byte(input int unsigned a);
    return phys.exists(a) ? phys[a] : 8'h00;
  endfunction

  function automatic logic [31:0] phys_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = phys_byte(a + i);
    return w;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      phys[a + i] = w[8*i +: 8];
      refm[a + i] = w[8*i +: 8];
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  // Little-endian read of n bytes; signed loads subtract 2^(8n) when the top bit is set
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [63:0] v;
    n = size_of(f3);
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + i);
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v - (64'd1 << (8*n));
    return v[31:0];
  endfunction

  function automatic req_t make_req(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] op2);
    req_t r;
    int n;
    logic [7:0] m;
    n = size_of(f3);
    m = 8'((1 << n) - 1) << (a % 4);
    r.we = wr;
    r.addr = a & ~32'd3;
    r.be = m[3:0];
    for (int j = 0; j < 4; j++) r.wd[8*j +: 8] = op2[8*(j % n) +: 8];
    return r;
  endfunction

  task automatic access(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] op2,
                        output int stall_cyc, output int lat);
    evt_t e;
    bit m, seen;
    m = (a % size_of(f3)) != 0;
    if (!m) begin
      exp_req.push_back(make_req(wr, f3, a, op2));
      if (wr) for (int i = 0; i < size_of(f3); i++) refm[a + i] = op2[8*i +: 8];
      else last_rd = ref_load(f3, a);
    end
    e.mis = m;
    e.rd = last_rd;
    exp_evt.push_back(e);
    memRead = !wr;
    memWrite = wr;
    funct3 = f3;
    aluResult = a;
    aluOp2 = op2;
    stall_cyc = 0;
    lat = 0;
    @(negedge clk);
    stall_cyc += int'(stall);
    @(posedge clk); #1;
    memRead = 1'b0;
    memWrite = 1'b0;
    funct3 = 3'($urandom);
    aluResult = $urandom;
    aluOp2 = $urandom;
    if (!m) begin
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
        @(negedge clk);
        stall_cyc += int'(stall);
        lat = k + 1;
        seen = done;
      end
      if (!seen) chk("done_timeout", 32'(seen), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  // A word load that is handshaken, then flushed or reset while waiting for its response
  task automatic killed_load(input bit use_reset, input logic [31:0] a);
    exp_req.push_back(make_req(1'b0, 3'd2, a, 32'h0));
    memRead = 1'b1;
    funct3 = 3'd2;
    aluResult = a;
    aluOp2 = 32'h0;
    @(posedge clk); #1;
    memRead = 1'b0;
    @(posedge clk); #1;
    if (use_reset) resetn = 1'b1;
    else flush = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    flush = 1'b0;
    if (use_reset) last_rd = '0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Memory responder: variable ready delay and response latency, applies writes with byte enables
  initial begin
    logic [31:0] a, wd;
    logic [3:0] be;
    logic we;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_req_valid || resetn) continue;
      repeat (ready_dly) @(negedge clk);
      if (!mem_req_valid) continue;
      a = mem_req_addr;
      be = mem_req_be;
      wd = mem_req_wdata;
      we = mem_req_we;
      mem_req_ready = 1'b1;
      if (rsp_dly == 0) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = phys_word(a);
      end
      @(posedge clk);
      if (we) for (int j = 0; j < 4; j++) if (be[j]) phys[a + j] = wd[8*j +: 8];
      #1;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      if (rsp_dly > 0) begin
        repeat (rsp_dly - 1) begin
          @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = phys_word(a);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
      end
    end
  end

  // Monitor: pops expected completions and requests whenever the DUT presents them
  initial begin
    evt_t e;
    req_t r, pr;
    bit pend;
    pend = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (resetn) begin
        pend = 1'b0;
        continue;
      end
      if (done || misalign) begin
        if (exp_evt.size() == 0) chk("unexpected_event", {30'd0, done, misalign}, 32'd0);
        else begin
          e = exp_evt.pop_front();
          chk("misalign", 32'(misalign), 32'(e.mis));
          chk("done", 32'(done), 32'(!e.mis));
          chk("readData", readData, e.rd);
        end
      end
      if (mem_req_valid && pend) begin
        chk("stable_addr", mem_req_addr, pr.addr);
        chk("stable_be", 32'(mem_req_be), 32'(pr.be));
        chk("stable_wdata", mem_req_wdata, pr.wd);
        chk("stable_we", 32'(mem_req_we), 32'(pr.we));
      end
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) chk("unexpected_request", mem_req_addr, 32'hFFFF_FFFF);
        else begin
          r = exp_req.pop_front();
          chk("req_we", 32'(mem_req_we), 32'(r.we));
          chk("req_addr", mem_req_addr, r.addr);
          chk("req_be", 32'(mem_req_be), 32'(r.be));
          chk("req_wdata", mem_req_wdata, r.wd);
        end
      end
      pend = mem_req_valid && !mem_req_ready;
      pr.addr = mem_req_addr;
      pr.be = mem_req_be;
      pr.wd = mem_req_wdata;
      pr.we = mem_req_we;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s, l;
    bit wr;
    logic [2:0] f3;
    logic [31:0] a;
    resetn = 1'b1;
    memRead = 1'b0;
    memWrite = 1'b0;
    flush = 1'b0;
    funct3 = '0;
    aluResult = '0;
    aluOp2 = '0;
    for (int i = 32'h1000; i < 32'h1048; i++) begin
      phys[i] = 8'($urandom);
      refm[i] = phys[i];
    end
    poke(32'h1000, 32'h80FF_0000);
    poke(32'h2000, 32'h0);
    poke(32'h3000, 32'hDEAD_BEEF);
    poke(32'h3010, 32'h55AA_55AA);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_readData", readData, 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);
    chk("rst_be", 32'(mem_req_be), 32'd0);
    chk("rst_wdata", mem_req_wdata, 32'd0);
    @(posedge clk); #1;

    ready_dly = 0; rsp_dly = 3;
    access(1'b0, 3'd0, 32'h1003, 32'h0, s, l);
    chk("lb_stall_cycles", s, 5);
    chk("lb_value", readData, 32'hFFFF_FF80);

    ready_dly = 0; rsp_dly = 0;
    access(1'b0, 3'd5, 32'h1002, 32'h0, s, l);
    chk("lhu_latency", l, 2);
    chk("lhu_value", readData, 32'h0000_80FF);

    ready_dly = 0; rsp_dly = 5;
    killed_load(1'b1, 32'h3000);
    chk("reset_wait_readData", readData, 32'd0);
    chk("reset_wait_stall", 32'(stall), 32'd0);

    ready_dly = 4; rsp_dly = 1;
    access(1'b1, 3'd1, 32'h2002, 32'h1234_ABCD, s, l);
    chk("sh_memory", phys_word(32'h2000), 32'hABCD_0000);

    access(1'b0, 3'd2, 32'h1001, 32'h0, s, l);
    chk("lw_mis_stall", s, 0);
    @(negedge clk);
    chk("lw_mis_no_valid", 32'(mem_req_valid), 32'd0);
    @(posedge clk); #1;

    ready_dly = 0; rsp_dly = 1;
    access(1'b0, 3'd2, 32'h1000, 32'h0, s, l);
    rsp_dly = 4;
    killed_load(1'b0, 32'h3010);
    chk("flush_readData_kept", readData, 32'h80FF_0000);
    chk("flush_stall", 32'(stall), 32'd0);
    rsp_dly = 1;
    access(1'b0, 3'd2, 32'h3010, 32'h0, s, l);
    chk("after_flush_lw", readData, 32'h55AA_55AA);

    for (int it = 0; it < 200; it++) begin
      ready_dly = $urandom_range(0, 3);
      rsp_dly = $urandom_range(0, 3);
      wr = $urandom_range(0, 2) == 0;
      f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      a = 32'h1000 + $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a = a - (a % size_of(f3));
      access(wr, f3, a, $urandom, s, l);
    end

    repeat (5) @(negedge clk);
    chk("events_drained", exp_evt.size(), 32'd0);
    chk("requests_drained", exp_req.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
